// File: rtl/shift_unit_seq_if.sv
//------------------------------------------------------------------------------
// Module      : shift_unit_seq_if
// Description : Request/response handshake bundle for the multi-cycle shifter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_unit_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid_i;
    logic               in_ready_o;
    logic [WIDTH-1:0]   data_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [1:0]         op_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [WIDTH-1:0]   result_o;

    modport slave (
        input  in_valid_i,
        input  data_i,
        input  shamt_i,
        input  op_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output result_o
    );

    modport master (
        output in_valid_i,
        output data_i,
        output shamt_i,
        output op_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  result_o
    );
endinterface

`default_nettype wire

// File: rtl/shift_unit_seq.sv
//------------------------------------------------------------------------------
// Module      : shift_unit_seq
// Description : Multi-cycle SLL/SRL/SRA(/ROR) shifter, at most STEP bits per
//               cycle, valid/ready in and out. Rotate built only when the
//               SHIFTER_ROTATE_EN macro is defined; otherwise op 2'b11 = SRL.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    shift_unit_seq_if.slave    bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] C_STEP = (SHAMT_W+1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   w_work_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [SHAMT_W-1:0] r_rem;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic [SHAMT_W-1:0] w_step;
    logic [1:0]         r_op;
    logic [1:0]         w_op_nxt;

    // Comparison is one bit wider so STEP == WIDTH is representable.
    always_comb begin
        w_step = C_STEP[SHAMT_W-1:0];
        if ({1'b0, r_rem} < C_STEP) begin
            w_step = r_rem;
        end
    end

    // Arithmetic shifts of the work register keep its MSB, which is the
    // operand sign latched at accept, so every step refills with that sign.
    always_comb begin
        w_shifted = r_work >> w_step;
        case (r_op)
            2'b00:   w_shifted = r_work << w_step;
            2'b10:   w_shifted = $signed(r_work) >>> w_step;
`ifdef SHIFTER_ROTATE_EN
            2'b11:   w_shifted = (r_work >> w_step) | (r_work << (WIDTH - int'(w_step)));
`endif
            default: w_shifted = r_work >> w_step;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    w_work_nxt  = bus.data_i;
                    w_rem_nxt   = bus.shamt_i;
                    w_op_nxt    = bus.op_i;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_work_nxt = w_shifted;
                w_rem_nxt  = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign bus.in_ready_o  = (r_state == ST_IDLE);
    assign bus.out_valid_o = (r_state == ST_DONE);
    assign bus.result_o    = r_work;

endmodule

`default_nettype wire

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised, multi-cycle shifter for the execute stage. Accepts an operand, a runtime shift amount and an operation (SLL/SRL/SRA, optional ROR). It shifts by at most STEP bits per cycle and returns the result over a valid/ready handshake. It generalises the fixed-amount combinational arithmetic right shifter to runtime amount, all shift kinds and configurable width and area/latency trade-off.

## Interface
- WIDTH, 32: operand/result width in bits; power of two, ≥ 8.
- STEP, 4: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; do not override).

- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- data_i  in  WIDTH  operand.
- shamt_i  in  SHAMT_W  shift amount, 0..WIDTH-1.
- op_i  in  2  2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROR (see Configuration).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH  shifted result.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o (accept edge), latch data_i into the work register, shamt_i into the remaining counter and op_i into the op register. Go to SHIFT.
- SHIFT:
  - Each cycle, apply step = min(STEP, remaining) to the work register using the latched op, then remaining -= step.
  - Go to DONE on the edge where the post-update remaining is 0. A zero shamt spends exactly one SHIFT cycle with step 0.
- DONE:
  - out_valid_o=1 and result_o = work register.
  - On out_ready_i, go to IDLE.
- Shift semantics:
  - SLL fills with zeros from the LSB.
  - SRL fills with zeros from the MSB.
  - SRA fills with bit WIDTH-1 of the operand latched at accept. Repeated steps preserve the sign.
  - ROR moves bits shifted out at the LSB into the MSB.
- Arithmetic: the remaining counter is SHAMT_W bits wide, and step never exceeds remaining, so no underflow.
- Inputs (data_i, shamt_i, op_i, in_valid_i) are ignored outside IDLE. There is no queueing.
- result_o holds stable while out_valid_o & !out_ready_i.
- Outside DONE, result_o shows the work register contents, which are meaningless to consumers.

## Timing
- Reset values:
  - in_ready_o=1, out_valid_o=0, result_o=0.
  - Work register 0, remaining 0, state IDLE.
- Latency: out_valid_o is first high in the cycle following the edge that is N = max(ceil(shamt/STEP), 1) edges after the accept edge.
  - WIDTH=32, STEP=4: shamt 0 → 1, shamt 5 → 2, shamt 31 → 8.
- Throughput: one request per N+2 cycles with out_ready_i held high. DONE→IDLE takes one edge; a new accept is possible in the IDLE cycle.
- in_ready_o and out_valid_o are registered state decodes. They never combinationally depend on in_valid_i or out_ready_i.
- in_ready_o and out_valid_o are never high in the same cycle.
- Reset mid-operation (SHIFT or DONE): the in-flight request is discarded. The next cycle shows reset values.
- rst_i has priority over any handshake on the same edge.

## Configuration
- SHIFTER_ROTATE_EN defined:
  - op 2'b11 performs rotate right by shamt (ROR).
  - The work register feeds back LSBs into the MSBs.
- SHIFTER_ROTATE_EN undefined:
  - No rotate logic is built.
  - op 2'b11 is decoded as SRL, with identical timing.

## Test plan
- SRA, data 0x8000_00F0, shamt 5 → result_o 0xFC00_0007; out_valid_o high 2 cycles after the accept edge.
- SLL, data 0x0000_0001, shamt 31 → result_o 0x8000_0000 after 8 cycles. Check that intermediate steps of 4 do not leak to out_valid_o.
- SRL, data 0xFFFF_FFFF, shamt 0 → result_o 0xFFFF_FFFF after 1 cycle. Then a back-to-back SRA 0xFFFF_FFFF shamt 31 → 0xFFFF_FFFF.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE. result_o and out_valid_o stay stable and in_ready_o=0. A pulsed in_valid_i with new data is ignored. Release → IDLE next cycle.
- Reset asserted during the 3rd SHIFT cycle of SLL shamt 20 → next cycle in_ready_o=1, out_valid_o=0, result_o=0. A subsequent request completes normally.
- op 2'b11, data 0x0000_00F1, shamt 4:
  - With SHIFTER_ROTATE_EN → 0x1000_000F.
  - Without → 0x0000_000F.
  - Both after 1 cycle.
